// File: rtl/wrr_pkg.sv
// Shared constants, types and FSM state codes for the 8-queue WRR scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wrr_pkg;

    localparam int NUM_Q     = 8;
    localparam int W_WIDTH   = 4;
    localparam int DEFAULT_W = 1;
    localparam int ID_W      = 3;

    typedef logic [W_WIDTH-1:0] credit_t;
    typedef logic [W_WIDTH-1:0] weight_t;
    typedef logic [ID_W-1:0]    qid_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_SERVE  = 2'd2;
    localparam logic [1:0] ST_RELOAD = 2'd3;

    function automatic logic [NUM_Q-1:0] qid_onehot(input qid_t id);
        return NUM_Q'(1) << id;
    endfunction

endpackage

// File: rtl/wrr_max_select.sv
// Combinational argmax of per-queue credit over the eligible mask.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any_eligible=0 means idx is meaningless.
// Ports: credit (packed per-queue credits), eligible (mask) -> idx, any_eligible.
module wrr_max_select
    import wrr_pkg::*;
(
    input  credit_t [NUM_Q-1:0] credit,
    input  logic    [NUM_Q-1:0] eligible,
    output qid_t                idx,
    output logic                any_eligible
);

    credit_t best_cred;

    // Ascending scan with >= lets a later (higher) index win any tie.
    always_comb begin
        best_cred    = '0;
        idx          = '0;
        any_eligible = 1'b0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (eligible[i] && (!any_eligible || credit[i] >= best_cred)) begin
                best_cred    = credit[i];
                idx          = qid_t'(i);
                any_eligible = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin read-grant scheduler over 8 queue FIFOs.
// Latency: grant_valid 1 cycle after SELECT; 1 word per 2 cycles at full rd_ready.
// Backpressure: grant held while rd_ready=0; withdrawn if its queue goes empty.
// Ports: clk/rst; cfg_wr/cfg_addr/cfg_weight program weights; empty in;
//        rd_ready in; grant_valid/grant_id/rd_en/round_done out.
module wrr_grant_scheduler
    import wrr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [ID_W-1:0]    cfg_addr,
    input  logic [W_WIDTH-1:0] cfg_weight,
    input  logic [NUM_Q-1:0]   empty,
    input  logic               rd_ready,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic [NUM_Q-1:0]   rd_en,
    output logic               round_done
);

    logic [1:0]          state_q, state_d;
    credit_t [NUM_Q-1:0] credit_q, credit_d;
    weight_t [NUM_Q-1:0] weight_q, weight_d;
    logic                grant_valid_q, grant_valid_d;
    qid_t                grant_id_q, grant_id_d;
    logic                round_done_q, round_done_d;

    logic [NUM_Q-1:0]    active;
    logic [NUM_Q-1:0]    eligible;
    qid_t                sel_idx;
    logic                sel_any;

    always_comb begin
        active   = '0;
        eligible = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            active[i]   = ~empty[i] & (weight_q[i] != '0);
            eligible[i] = ~empty[i] & (credit_q[i] != '0);
        end
    end

    wrr_max_select u_max_select (
        .credit       (credit_q),
        .eligible     (eligible),
        .idx          (sel_idx),
        .any_eligible (sel_any)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        weight_d      = weight_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        round_done_d  = 1'b0;

        // Weight writes land in any state; credits only pick them up on reload.
        if (cfg_wr) begin
            weight_d[cfg_addr] = cfg_weight;
        end

        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (!sel_any) begin
                    state_d      = ST_RELOAD;
                    round_done_d = 1'b1;    // high for exactly the RELOAD cycle
                end else begin
                    grant_valid_d = 1'b1;
                    grant_id_d    = sel_idx;
                    state_d       = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // A transfer wins over a simultaneous empty; selection only
                // picks non-zero credit, so the decrement cannot wrap.
                if (grant_valid_q && rd_ready) begin
                    credit_d[grant_id_q] = credit_q[grant_id_q] - 1'b1;
                    grant_valid_d        = 1'b0;
                    state_d              = ST_SELECT;
                end else if (empty[grant_id_q]) begin
                    grant_valid_d = 1'b0;
                    state_d       = ST_SELECT;
                end
            end
            ST_RELOAD: begin
                // Uses weight_q, so a same-cycle cfg_wr affects the next round.
                credit_d = weight_q;
                state_d  = (|active) ? ST_SELECT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            weight_q      <= {NUM_Q{weight_t'(DEFAULT_W)}};
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            round_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            weight_q      <= weight_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            round_done_q  <= round_done_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign round_done  = round_done_q;
    assign rd_en       = qid_onehot(grant_id_q) & {NUM_Q{grant_valid_q & rd_ready}};

endmodule

// File: doc/wrr_grant_scheduler.md
Name: wrr_grant_scheduler

Overview:
- Sequential weighted-round-robin scheduler for the 8-queue WRR FIFO subsystem.
- Holds a programmable weight per queue and a per-queue credit counter reloaded from it.
- Each cycle it is free, it picks the non-empty queue with the highest remaining credit and issues a one-word read grant through a valid/ready handshake.
- Sits between the eight queue FIFOs (empty flags, read enables) and the SRAM write-side consumer (rd_ready).

Parameters:
- NUM_Q, 8, number of queues; fixed at 8 in this revision.
- W_WIDTH, 4, bit width of weights and credits.
- DEFAULT_W, 1, weight loaded into every queue on reset.

Ports:
- clk  input  1  system clock; all state rising-edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_wr  input  1  weight write strobe.
- cfg_addr  input  3  queue index for cfg_wr.
- cfg_weight  input  W_WIDTH  weight value written; 0 disables the queue.
- empty  input  NUM_Q  per-queue FIFO empty flag; bit i is queue i.
- rd_ready  input  1  consumer accepts one word this cycle.
- grant_valid  output  1  grant presented; registered.
- grant_id  output  3  granted queue index; registered.
- rd_en  output  NUM_Q  one-hot FIFO read enable; equals onehot(grant_id) & {NUM_Q{grant_valid & rd_ready}}.
- round_done  output  1  one-cycle pulse when credits are reloaded.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; all credits=0; all weights=DEFAULT_W.
  - grant_valid=0, grant_id=0, round_done=0; rd_en therefore 0.
- Definitions:
  - active[i] = ~empty[i] & (weight[i]!=0).
  - eligible[i] = ~empty[i] & (credit[i]!=0).
- States: IDLE, SELECT, SERVE, RELOAD. Encoding is defined in the package.
- IDLE: if |active, go to SELECT next cycle; otherwise stay.
- SELECT (1 cycle):
  - If eligible==0, go to RELOAD.
  - Otherwise register grant_id = index of the maximum credit among eligible queues, set grant_valid=1, go to SERVE.
  - Ties resolve to the highest index.
- SERVE:
  - grant_valid and grant_id are held stable until the handshake completes.
  - On grant_valid & rd_ready:
    - rd_en[grant_id]=1 that cycle.
    - credit[grant_id] decrements by 1 at the clock edge.
    - grant_valid clears and state returns to SELECT, so arbitration repeats per word.
  - Throughput: 1 word per 2 cycles at full rd_ready. Latency from SELECT entry to first grant_valid is 1 cycle.
  - If empty[grant_id]=1 and rd_ready=0: grant is withdrawn (grant_valid=0 next cycle), credit unchanged, go to SELECT.
  - If empty[grant_id]=1 and rd_ready=1 in the same cycle: the transfer wins, and the credit is decremented.
- RELOAD (1 cycle):
  - credit[i] <= weight[i] for all i; round_done=1 for this cycle.
  - Go to SELECT if |active, else IDLE.
- Credit arithmetic: unsigned W_WIDTH. A decrement is only possible when credit is non-zero, so there is no underflow and no wrap.
- Config:
  - cfg_wr updates weight[cfg_addr] at the next edge in any state.
  - Credits are not touched; the new weight takes effect at the next RELOAD.
  - cfg_wr in the same cycle as RELOAD: the reload uses the old weight.
- No spinning:
  - Weight-0 queues never receive credit.
  - If only weight-0 queues are non-empty, the scheduler rests in IDLE with no round_done pulses.

Decomposition:
- Package wrr_pkg: NUM_Q, W_WIDTH, DEFAULT_W, state enum/localparams, credit_t/weight_t widths.
- Sub-module wrr_max_select:
  - Combinational argmax over NUM_Q credits masked by eligible.
  - Outputs index and any_eligible; highest-index tie-break.
  - Instantiated once in the SELECT path.

Test Plan:
1. Reset, weights default 1, empty=8'h00, rd_ready=1 -> round_done, then grant_id 7,6,5,4,3,2,1,0 (one every 2 cycles), round_done, then the sequence repeats.
2. cfg writes w0=3, w1=1, w2..7=0; empty=8'hFC; rd_ready=1 -> per round grant_id sequence 0,0,1,0, then round_done; exactly 4 grants per round.
3. Granted queue 3, rd_ready=0 for 5 cycles -> grant_valid=1 and grant_id=3 stable, rd_en=0, credit[3] unchanged; rd_ready=1 -> rd_en=8'h08 for one cycle, credit[3] decrements by 1.
4. In SERVE on q3 with rd_ready=0, empty[3] rises -> grant_valid=0 next cycle, credit[3] unchanged, next grant goes to another eligible queue.
5. empty=8'hFF, or only weight-0 queues non-empty -> stays in IDLE; grant_valid=0, round_done never pulses over 50 cycles.
6. rst asserted mid-SERVE between clock edges -> grant_valid, rd_en and round_done go to 0 immediately; after release all weights=1 and the first action is a RELOAD.
